uart_alu_sequencer: RTL and testbench

Frame controller between the UART receiver/transmitter and the ALU in the UART–ALU top. It collects three received bytes in order: operand A, operand B, opcode. It drives the ALU operand and opcode registers, then captures the ALU result and hands it to the transmitter with a one-cycle start pulse. It also resynchronises on inter-byte timeout, rejects illegal opcodes, and runs a transmit watchdog.

---
 rtl/uart_alu_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_sequencer.sv
// ---------------------------------------------------------------------------
// uart_alu_sequencer
//
// Frame controller that sits between a UART receiver/transmitter pair and an
// ALU. It collects three bytes in order (operand A, operand B, opcode) and
// presents them to the ALU as registered operands. It then captures the ALU
// result and hands it to the transmitter with a one-cycle start pulse. It also
// handles these fault cases:
//   - a stalled frame, resynchronised by an inter-byte timeout;
//   - an illegal opcode, which is rejected;
//   - a missing tx_done, caught by a transmit watchdog.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_rx_done    one-cycle pulse, i_rx_data valid in that cycle
//   i_rx_data    received byte
//   i_alu_result combinational ALU result for o_data_a/o_data_b/o_op
//   i_tx_done    one-cycle pulse at the end of the transmitted stop bit
//   o_data_a     registered operand A
//   o_data_b     registered operand B
//   o_op         registered opcode
//   o_tx_start   one-cycle transmit start pulse
//   o_tx_data    byte to transmit, stable from the start pulse until idle
//   o_busy       high whenever a frame is in progress
//   o_err        sticky error code: 00 none, 01 rx timeout, 10 bad opcode,
//                11 tx watchdog; cleared when the next frame's A is accepted
// ---------------------------------------------------------------------------
module uart_alu_sequencer #(
  parameter int DBIT    = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 50000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_rx_done,
  input  logic [DBIT-1:0]  i_rx_data,
  input  logic [DBIT-1:0]  i_alu_result,
  input  logic             i_tx_done,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_op,
  output logic             o_tx_start,
  output logic [DBIT-1:0]  o_tx_data,
  output logic             o_busy,
  output logic [1:0]       o_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RX_TO   = 2'b01;
  localparam logic [1:0] ERR_BAD_OP  = 2'b10;
  localparam logic [1:0] ERR_TX_WDOG = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DBIT-1:0]  data_a_q, data_a_d;
  logic [DBIT-1:0]  data_b_q, data_b_d;
  logic [NB_OP-1:0] op_q, op_d;
  logic [DBIT-1:0]  tx_data_q, tx_data_d;
  logic [1:0]       err_q, err_d;

  logic [NB_OP-1:0] rx_op;
  logic             cnt_expired;

  // Only the ALU functions implemented downstream are accepted.
  function automatic logic op_legal(input logic [NB_OP-1:0] op);
    logic ok;
    ok = 1'b0;
    if (op == NB_OP'(6'b100000) || op == NB_OP'(6'b100010) ||
        op == NB_OP'(6'b100100) || op == NB_OP'(6'b100101) ||
        op == NB_OP'(6'b100110) || op == NB_OP'(6'b100111) ||
        op == NB_OP'(6'b000011) || op == NB_OP'(6'b000010))
      ok = 1'b1;
    return ok;
  endfunction

  // Saturating increment, so a long stall cannot wrap the counter back
  // below the limit.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  assign rx_op       = i_rx_data[NB_OP-1:0];
  assign cnt_expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          err_d    = ERR_NONE;
          cnt_d    = '0;
          state_d  = WAIT_B;
        end
      end

      WAIT_B: begin
        // An arriving byte takes priority over an expiring counter.
        if (i_rx_done) begin
          data_b_d = i_rx_data;
          cnt_d    = '0;
          state_d  = WAIT_OP;
        end else if (cnt_expired) begin
          err_d   = ERR_RX_TO;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      WAIT_OP: begin
        if (i_rx_done) begin
          if (op_legal(rx_op)) begin
            op_d    = rx_op;
            state_d = EXEC;
          end else begin
            err_d   = ERR_BAD_OP;
            state_d = IDLE;
          end
        end else if (cnt_expired) begin
          err_d   = ERR_RX_TO;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      // o_op became valid on entry here, so the ALU result is settled.
      EXEC: begin
        tx_data_d = i_alu_result;
        state_d   = SEND;
      end

      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_TX;
      end

      // Received bytes are dropped here; only tx_done or the watchdog exits.
      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = IDLE;
        end else if (cnt_expired) begin
          err_d   = ERR_TX_WDOG;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_err      = err_q;
  assign o_tx_start = (state_q == SEND);
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
module tb_uart_alu_sequencer;

  localparam int DBIT    = 8;
  localparam int NB_OP   = 6;
  localparam int TIMEOUT = 100;

  logic             clk;
  logic             rst;
  logic             rx_done;
  logic [DBIT-1:0]  rx_data;
  logic [DBIT-1:0]  alu_res;
  logic             tx_done;
  logic [DBIT-1:0]  data_a;
  logic [DBIT-1:0]  data_b;
  logic [NB_OP-1:0] op;
  logic             tx_start;
  logic [DBIT-1:0]  tx_data;
  logic             busy;
  logic [1:0]       err;

  int checks;
  int errors;
  int tx_pulses;
  int p0;

  uart_alu_sequencer #(
    .DBIT(DBIT), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_alu_result(alu_res), .i_tx_done(tx_done),
    .o_data_a(data_a), .o_data_b(data_b), .o_op(op), .o_tx_start(tx_start),
    .o_tx_data(tx_data), .o_busy(busy), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU driven by the sequencer's registered operands.
  always_comb begin
    alu_res = '0;
    case (op)
      6'b100000: alu_res = data_a + data_b;
      6'b100010: alu_res = data_a - data_b;
      6'b100100: alu_res = data_a & data_b;
      6'b100101: alu_res = data_a | data_b;
      6'b100110: alu_res = data_a ^ data_b;
      6'b100111: alu_res = ~(data_a | data_b);
      6'b000011: alu_res = $signed(data_a) >>> data_b;
      6'b000010: alu_res = data_a >> data_b;
      default:   alu_res = '0;
    endcase
  end

  always @(posedge clk) if (tx_start) tx_pulses <= tx_pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] opb, input logic [7:0] res);
    int p;
    send_byte(a);
    chk({tag, "_busyA"}, busy, 1);
    chk({tag, "_errA"}, err, 0);
    chk({tag, "_dataA"}, data_a, a);
    send_byte(b);
    chk({tag, "_dataB"}, data_b, b);
    p = tx_pulses;
    send_byte(opb);
    chk({tag, "_op"}, op, opb[5:0]);
    chk({tag, "_start_n1"}, tx_start, 0);
    tick();
    chk({tag, "_start_n2"}, tx_start, 1);
    chk({tag, "_txdata"}, tx_data, res);
    tick();
    chk({tag, "_start_n3"}, tx_start, 0);
    chk({tag, "_pulses"}, tx_pulses, p + 1);
    chk({tag, "_txhold"}, tx_data, res);
    chk({tag, "_busyTx"}, busy, 1);
    pulse_tx_done();
    chk({tag, "_busyEnd"}, busy, 0);
    chk({tag, "_errEnd"}, err, 0);
  endtask

  initial begin
    checks = 0; errors = 0; tx_pulses = 0;
    rst = 1'b1; rx_done = 1'b0; rx_data = '0; tx_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_a", data_a, 0);
    chk("rst_op", op, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_start", tx_start, 0);

    // Test 1: ADD 5+3
    run_frame("t1", 8'h05, 8'h03, 8'h20, 8'h08);
    chk("t1_b", data_b, 8'h03);

    // Test 2: SRL then AND back to back
    run_frame("t2a", 8'h0F, 8'h01, 8'h02, 8'h07);
    run_frame("t2b", 8'hF0, 8'h0F, 8'h24, 8'h00);

    // Test 3: timeout in WAIT_B; decision cycle is the one with counter 99
    p0 = tx_pulses;
    send_byte(8'h11);
    repeat (TIMEOUT - 1) tick();
    chk("t3_busyLast", busy, 1);
    chk("t3_errLast", err, 0);
    tick();
    chk("t3_busyTo", busy, 0);
    chk("t3_errTo", err, 1);
    tick();
    chk("t3_errHold", err, 1);
    chk("t3_noStart", tx_pulses, p0);
    run_frame("t3f", 8'h02, 8'h03, 8'h20, 8'h05);

    // Test 4: illegal opcode 0x3F
    p0 = tx_pulses;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h3F);
    chk("t4_err", err, 2);
    chk("t4_opKeep", op, 6'b100000);
    chk("t4_busy", busy, 0);
    tick(); tick();
    chk("t4_noStart", tx_pulses, p0);
    chk("t4_errHold", err, 2);

    // Test 5: SUB 6-2, tx_done withheld, stray rx byte in WAIT_TX
    send_byte(8'h06);
    chk("t5_errClr", err, 0);
    send_byte(8'h02);
    send_byte(8'h22);
    tick();
    chk("t5_start", tx_start, 1);
    chk("t5_txdata", tx_data, 8'h04);
    tick();
    send_byte(8'hAA);
    chk("t5_dropBusy", busy, 1);
    chk("t5_dropA", data_a, 8'h06);
    repeat (TIMEOUT - 2) tick();
    chk("t5_busyLast", busy, 1);
    chk("t5_errLast", err, 0);
    tick();
    chk("t5_busyWd", busy, 0);
    chk("t5_errWd", err, 3);

    // Test 6a: reset in WAIT_OP
    p0 = tx_pulses;
    send_byte(8'h07);
    send_byte(8'h08);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6a_busy", busy, 0);
    chk("t6a_a", data_a, 0);
    chk("t6a_b", data_b, 0);
    chk("t6a_op", op, 0);
    chk("t6a_err", err, 0);
    tick(); tick();
    chk("t6a_noStart", tx_pulses, p0);

    // Test 6b: reset in WAIT_TX (OR 0x30|0x05 = 0x35)
    send_byte(8'h30);
    send_byte(8'h05);
    send_byte(8'h25);
    tick();
    chk("t6b_txdata", tx_data, 8'h35);
    tick();
    chk("t6b_busyTx", busy, 1);
    p0 = tx_pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6b_busy", busy, 0);
    chk("t6b_txd", tx_data, 0);
    chk("t6b_a", data_a, 0);
    chk("t6b_op", op, 0);
    chk("t6b_start", tx_start, 0);
    tick();
    chk("t6b_noStart", tx_pulses, p0);

    // Test 6c: B byte lands exactly on the expiry cycle (counter 99)
    send_byte(8'h09);
    repeat (TIMEOUT - 1) tick();
    send_byte(8'h0A);
    chk("t6c_busy", busy, 1);
    chk("t6c_b", data_b, 8'h0A);
    chk("t6c_err", err, 0);
    send_byte(8'h26);
    chk("t6c_op", op, 6'b100110);
    tick();
    chk("t6c_start", tx_start, 1);
    chk("t6c_txdata", tx_data, 8'h03);
    tick();
    pulse_tx_done();
    chk("t6c_busyEnd", busy, 0);
    chk("t6c_errEnd", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
